// File: rtl/param_cmd_fifo.sv
// Single-clock show-ahead command FIFO with level flags, flush and sticky
// overflow/underflow indicators.
module param_cmd_fifo #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 8,
   parameter int AFULL_LVL  = (1 << ADDR_W) - 4,
   parameter int AEMPTY_LVL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data,
   input  logic              wrreq,
   output logic              wrfull,
   output logic [DATA_W-1:0] q,
   input  logic              rdreq,
   output logic              rdempty,
   output logic [ADDR_W:0]   usedw,
   output logic              almost_full,
   output logic              almost_empty,
   input  logic              flush,
   output logic              ovf,
   output logic              udf,
   input  logic              clr_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_LVL);
   localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_LVL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] put_ptr;
   logic [ADDR_W-1:0] get_ptr;
   logic [ADDR_W:0]   cnt;
   logic              wr_acc;
   logic              rd_acc;
   logic              ovf_set;
   logic              udf_set;

   assign rdempty      = (cnt == '0);
   assign wrfull       = (cnt == DEPTH_C);
   assign almost_full  = (cnt >= AFULL_C);
   assign almost_empty = (cnt <= AEMPTY_C);
   assign usedw        = cnt;
   assign q            = mem[get_ptr];

   // A full FIFO still takes a write when a read frees a slot in the same edge.
   assign rd_acc  = rdreq & ~rdempty & ~flush;
   assign wr_acc  = wrreq & (~wrfull | rd_acc) & ~flush;
   assign ovf_set = wrreq & ~flush & ~wr_acc;
   assign udf_set = rdreq & rdempty & ~flush;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[put_ptr] <= data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         put_ptr <= '0;
         get_ptr <= '0;
         cnt     <= '0;
      end else if (flush) begin
         put_ptr <= '0;
         get_ptr <= '0;
         cnt     <= '0;
      end else begin
         if (wr_acc) begin
            put_ptr <= put_ptr + 1'b1;
         end
         if (rd_acc) begin
            get_ptr <= get_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // A new error event outranks a clear arriving in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (ovf_set) begin
            ovf <= 1'b1;
         end else if (clr_err) begin
            ovf <= 1'b0;
         end
         if (udf_set) begin
            udf <= 1'b1;
         end else if (clr_err) begin
            udf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_param_cmd_fifo.sv
// Scoreboard bench for param_cmd_fifo: queue-based reference model plus a
// negedge monitor that compares every output each cycle.
module tb_param_cmd_fifo;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data = '0;
   logic        wrreq = 1'b0;
   logic        rdreq = 1'b0;
   logic        flush = 1'b0;
   logic        clr_err = 1'b0;
   logic        wrfull, rdempty, almost_full, almost_empty, ovf, udf;
   logic [31:0] q;
   logic [4:0]  usedw;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] exp_q[$];
   int          m_cnt = 0;
   logic        m_ovf = 1'b0;
   logic        m_udf = 1'b0;
   logic        m_wok, m_rok;

   logic        w_b, r_b, f_b, c_b;
   logic [31:0] pat;

   param_cmd_fifo #(
      .DATA_W(32), .ADDR_W(4), .AFULL_LVL(12), .AEMPTY_LVL(2)
   ) dut (
      .clk(clk), .rst(rst), .data(data), .wrreq(wrreq), .wrfull(wrfull),
      .q(q), .rdreq(rdreq), .rdempty(rdempty), .usedw(usedw),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .flush(flush), .ovf(ovf), .udf(udf), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   // Reference model: occupancy and data order as a plain queue.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_cnt = 0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         m_rok = rdreq && !flush && (m_cnt > 0);
         m_wok = wrreq && !flush && ((m_cnt < DEPTH) || m_rok);
         if (flush) begin
            exp_q.delete();
            m_cnt = 0;
         end else begin
            if (m_wok) exp_q.push_back(data);
            m_cnt = m_cnt + int'(m_wok) - int'(m_rok);
         end
         if (wrreq && !flush && !m_wok) m_ovf = 1'b1;
         else if (clr_err)              m_ovf = 1'b0;
         if (rdreq && !flush && (m_cnt == 0) && !m_wok && !m_rok) m_udf = 1'b1;
         else if (rdreq && !flush && !m_rok)                       m_udf = 1'b1;
         else if (clr_err)                                         m_udf = 1'b0;
      end
   end

   // Monitor: every output against the model; q popped on each read accept.
   always @(negedge clk) begin
      if (!rst) begin
         chk("usedw", 32'(usedw), 32'(m_cnt));
         chk("rdempty", 32'(rdempty), 32'(m_cnt == 0));
         chk("wrfull", 32'(wrfull), 32'(m_cnt == DEPTH));
         chk("almost_full", 32'(almost_full), 32'(m_cnt >= 12));
         chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
         chk("ovf", 32'(ovf), 32'(m_ovf));
         chk("udf", 32'(udf), 32'(m_udf));
         if (rdreq && !flush && (m_cnt > 0)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL q: read with scoreboard empty at %0t", $time);
            end else begin
               chk("q", q, exp_q[0]);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step(input logic w, input logic [31:0] d, input logic r,
                       input logic f, input logic c);
      wrreq = w; data = d; rdreq = r; flush = f; clr_err = c;
      @(posedge clk);
      #1;
      wrreq = 1'b0; rdreq = 1'b0; flush = 1'b0; clr_err = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_usedw", 32'(usedw), 32'd0);
      chk("rst_rdempty", 32'(rdempty), 32'd1);
      chk("rst_wrfull", 32'(wrfull), 32'd0);
      chk("rst_aempty", 32'(almost_empty), 32'd1);
      chk("rst_afull", 32'(almost_full), 32'd0);
      chk("rst_flags", {30'd0, ovf, udf}, 32'd0);

      // Fill, overflow, drain
      for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
      chk("fill_wrfull", 32'(wrfull), 32'd1);
      chk("fill_usedw", 32'(usedw), 32'd16);
      step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      chk("ovf_set", 32'(ovf), 32'd1);
      chk("ovf_usedw", 32'(usedw), 32'd16);
      chk("ovf_q", q, 32'h100);
      for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("drain_rdempty", 32'(rdempty), 32'd1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("clr_ovf", 32'(ovf), 32'd0);

      // Thresholds up and down (monitor tracks flags each cycle)
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
         if (i == 1) chk("aempty_at2", 32'(almost_empty), 32'd1);
         if (i == 2) chk("aempty_at3", 32'(almost_empty), 32'd0);
         if (i == 10) chk("afull_at11", 32'(almost_full), 32'd0);
      end
      chk("afull_at12", 32'(almost_full), 32'd1);
      for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Simultaneous read/write at full and at empty
      for (int i = 0; i < 16; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hABCD, 1'b1, 1'b0, 1'b0);
      chk("full_rw_usedw", 32'(usedw), 32'd16);
      chk("full_rw_ovf", 32'(ovf), 32'd0);
      for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("abcd_last", q, 32'hABCD);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
      chk("empty_rw_usedw", 32'(usedw), 32'd1);
      chk("empty_rw_udf", 32'(udf), 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

      // Wrap-around: occupancy kept within 1..15
      pat = 32'h1000;
      step(1'b1, pat, 1'b0, 1'b0, 1'b0);
      pat++;
      for (int i = 0; i < 40; i++) begin
         w_b = 1'($urandom_range(0, 1));
         r_b = 1'($urandom_range(0, 1));
         if (m_cnt + int'(w_b) - int'(r_b) > 15) w_b = 1'b0;
         if (m_cnt + int'(w_b) - int'(r_b) < 1)  r_b = 1'b0;
         step(w_b, pat, r_b, 1'b0, 1'b0);
         if (w_b) pat++;
      end

      // Unconstrained random traffic including errors, flushes and clears
      for (int i = 0; i < 300; i++) begin
         w_b = ($urandom_range(0, 9) < 6);
         r_b = ($urandom_range(0, 9) < 5);
         f_b = ($urandom_range(0, 40) == 0);
         c_b = ($urandom_range(0, 15) == 0);
         step(w_b, $urandom, r_b, f_b, c_b);
      end

      // Flush keeps flags; clear removes them; set beats clear
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h5FF, 1'b1, 1'b1, 1'b0);
      chk("flush_usedw", 32'(usedw), 32'd0);
      chk("flush_rdempty", 32'(rdempty), 32'd1);
      chk("flush_udf_kept", 32'(udf), 32'd1);
      chk("flush_ovf_kept", 32'(ovf), 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("clr_flags", {30'd0, ovf, udf}, 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      chk("set_beats_clr", 32'(udf), 32'd1);

      // Asynchronous reset mid-cycle with 7 words stored
      for (int i = 0; i < 7; i++) step(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0);
      chk("pre_rst_usedw", 32'(usedw), 32'd7);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_usedw", 32'(usedw), 32'd0);
      chk("arst_rdempty", 32'(rdempty), 32'd1);
      chk("arst_flags", {30'd0, ovf, udf}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
      chk("post_rst_q", q, 32'h55);
      chk("post_rst_usedw", 32'(usedw), 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/param_cmd_fifo.md
PARAM_CMD_FIFO -- requirements
Module: param_cmd_fifo

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- DATA_W, 32, word width in bits.
- ADDR_W, 8, pointer width; DEPTH = 2^ADDR_W words.
- AFULL_LVL, 2^ADDR_W-4, almost_full threshold.
- AEMPTY_LVL, 4, almost_empty threshold.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- data, in, DATA_W, write data.
- wrreq, in, 1, write request.
- wrfull, out, 1, high when usedw == DEPTH.
- q, out, DATA_W, oldest stored word (show-ahead).
- rdreq, in, 1, read request; consumes q.
- rdempty, out, 1, high when usedw == 0.
- usedw, out, ADDR_W+1, stored word count, 0..DEPTH.
- almost_full, out, 1, high when usedw >= AFULL_LVL.
- almost_empty, out, 1, high when usedw <= AEMPTY_LVL.
- flush, in, 1, synchronous discard of all contents.
- ovf, out, 1, sticky overflow flag.
- udf, out, 1, sticky underflow flag.
- clr_err, in, 1, synchronous clear of ovf and udf.

REQ-003 The one clock and asynchronous active-high reset are fixed: clk, rst; no second clock domain.

Function
REQ-004 Storage SHALL be a DEPTH x DATA_W array with ADDR_W-bit put_ptr and get_ptr that wrap modulo DEPTH, and an (ADDR_W+1)-bit counter. All DEPTH entries SHALL be usable.
REQ-005 Write accept SHALL be wrreq & (~wrfull | rd_acc). On accept: mem[put_ptr] <= data, put_ptr +1.
REQ-006 Read accept (rd_acc) SHALL be rdreq & ~rdempty. On accept: get_ptr +1.
REQ-007 usedw SHALL update as follows:
- +1 on write-only accept.
- -1 on read-only accept.
- Unchanged when write and read are accepted in the same cycle.
- Never leaves the range 0..DEPTH.
REQ-008 Simultaneous wrreq and rdreq when full SHALL accept both; usedw stays DEPTH and wrfull stays high.
REQ-009 Simultaneous wrreq and rdreq when empty SHALL accept only the write; usedw becomes 1 and udf is set.
REQ-010 q SHALL equal mem[get_ptr]. q is valid whenever rdempty = 0 and is don't-care while rdempty = 1.
REQ-011 A word written at edge k SHALL appear on q, with rdempty low, after edge k (fall-through latency of 1 clock).
REQ-012 wrfull, rdempty, almost_full and almost_empty SHALL be combinational decodes of the registered usedw, so they are valid in the same cycle as usedw.
REQ-013 flush SHALL zero put_ptr, get_ptr and usedw at the edge. flush overrides wrreq and rdreq in the same cycle; neither is accepted and no error flag is set by them.
REQ-014 ovf SHALL set at an edge where wrreq = 1 and the write is not accepted. udf SHALL set at an edge where rdreq = 1, rdempty = 1 and flush = 0.
REQ-015 clr_err SHALL clear ovf and udf. If a new error event occurs in the same cycle, the set wins. flush SHALL NOT clear the flags.
REQ-016 Rejected writes SHALL NOT modify memory or pointers.

Reset
REQ-017 rst high SHALL asynchronously force:
- put_ptr = get_ptr = usedw = 0.
- rdempty = 1, wrfull = 0, almost_empty = 1, almost_full = 0 (AFULL_LVL > 0).
- ovf = udf = 0.
REQ-018 Memory contents SHALL NOT be reset. q is don't-care during and after reset until the first write.
REQ-019 rst asserted mid-operation SHALL discard all contents. The first write after rst deassertion SHALL be stored at address 0.

Verification (DATA_W=32, ADDR_W=4, AFULL_LVL=12, AEMPTY_LVL=2)
REQ-020 Fill and drain:
- Stimulus: write 0x100..0x10F on 16 consecutive cycles, then write 0x200.
- Required: wrfull = 1 and usedw = 16 after the 16th write; the 0x200 write sets ovf = 1 and changes nothing else.
- Then read 16 words: q sequence 0x100..0x10F, then rdempty = 1.
REQ-021 Thresholds:
- Stimulus: write 12 words one at a time.
- Required: almost_empty falls when usedw goes 2->3; almost_full rises at usedw = 12; both track usedw exactly on the way down.
REQ-022 Wrap-around:
- Stimulus: 40 interleaved writes and reads of an incrementing pattern, with occupancy between 1 and 15.
- Required: data returned in order with no loss, and usedw matches a reference model every cycle.
REQ-023 Simultaneous read/write:
- Stimulus: at full, drive wrreq and rdreq together with data = 0xABCD.
- Required: usedw stays 16, ovf = 0, and 0xABCD is read out last.
- Stimulus: when empty, drive wrreq and rdreq together.
- Required: usedw = 1 and udf = 1.
REQ-024 Flush and clear:
- Stimulus: hold 5 words, assert flush with wrreq = 1.
- Required: usedw = 0 and rdempty = 1 next cycle; the flags are unchanged.
- Stimulus: assert clr_err.
- Required: ovf = udf = 0.
REQ-025 Asynchronous reset:
- Stimulus: assert rst between clock edges while 7 words are stored.
- Required: usedw = 0, rdempty = 1 and flags = 0 immediately, before the next edge.
- Stimulus: after release, write 0x55.
- Required: q = 0x55 one cycle later.
